// File: rtl/uart_pkg.sv
// Shared ASCII constants and FSM state type for the UART hex reply path.
// No logic; zero latency; no flow control.
package uart_pkg;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_a  = 8'h61;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/hex_ascii_enc.sv
// Nibble to ASCII hex digit; purely combinational (0 cycles), no backpressure.
// Case of A-F selected by UPPERCASE.
module hex_ascii_enc
    import uart_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    localparam logic [7:0] ALPHA = UPPERCASE ? ASCII_A : ASCII_a;

    always_comb begin
        if (nibble <= 4'd9) begin
            ascii = ASCII_0 + {4'd0, nibble};
        end else begin
            ascii = ALPHA + {4'd0, nibble} - 8'd10;
        end
    end
endmodule

// File: rtl/uart_hex_reply_tx.sv
// Sends each captured result to uart_tx as ASCII hex (+ optional CR LF); first tx_start 1 cycle after capture.
// Paced by tx_done_tick; result_ready low while a frame is in flight, pulses arriving then are counted and dropped.
module uart_hex_reply_tx
    import uart_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DBIT      = 8,
    parameter bit SEND_CRLF = 1'b1,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result,
    output logic              result_ready,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    output logic              busy,
    output logic [7:0]        drop_count
);
    localparam int NIBBLES = DATA_W / 4;
    localparam int LAST    = NIBBLES - 1 + (SEND_CRLF ? 2 : 0);
    localparam int IDX_W   = $clog2(NIBBLES + 2);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  next_index;
    logic [3:0]        nibble;
    logic [7:0]        digit;
    logic [7:0]        next_char;

    // The character for the upcoming tx_start is prepared one cycle early so tx_din is registered:
    // from the live input at capture, otherwise from the digit just below the one being sent.
    always_comb begin
        next_index = (state == IDLE) ? '0 : index + 1'b1;
        nibble     = (state == IDLE) ? result[DATA_W-1 -: 4] : shreg[DATA_W-5 -: 4];
    end

    hex_ascii_enc #(.UPPERCASE(UPPERCASE)) u_enc (
        .nibble(nibble),
        .ascii (digit)
    );

    always_comb begin
        if (int'(next_index) < NIBBLES) begin
            next_char = digit;
        end else if (int'(next_index) == NIBBLES) begin
            next_char = ASCII_CR;
        end else begin
            next_char = ASCII_LF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            index        <= '0;
            shreg        <= '0;
            tx_start     <= 1'b0;
            tx_din       <= '0;
            busy         <= 1'b0;
            result_ready <= 1'b1;
            drop_count   <= '0;
        end else begin
            tx_start <= 1'b0;
            if (result_valid && state != IDLE && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (result_valid) begin
                        shreg        <= result;
                        index        <= '0;
                        busy         <= 1'b1;
                        result_ready <= 1'b0;
                        tx_start     <= 1'b1;
                        tx_din       <= DBIT'(next_char);
                        state        <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (tx_done_tick) begin
                        if (index == IDX_W'(LAST)) begin
                            busy         <= 1'b0;
                            result_ready <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            index    <= next_index;
                            shreg    <= shreg << 4;
                            tx_start <= 1'b1;
                            tx_din   <= DBIT'(next_char);
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_hex_reply_tx.sv
// Bench for uart_hex_reply_tx: two instances (CRLF+uppercase, bare lowercase) each driving a stub uart_tx,
// checked every cycle against a character-level frame model plus directed literal expectations.
module tb_uart_hex_reply_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rv0, rv1, inj0, inj1;
    logic [31:0] res0, res1;
    logic        rdy0, rdy1, ts0, ts1, busy0, busy1, done0, done1;
    logic [7:0]  din0, din1, drop0, drop1;
    logic        sd0 = 1'b0, sd1 = 1'b0;
    int          cd0 = 0, cd1 = 0;
    int          cyc = 0;

    assign done0 = sd0 | inj0;
    assign done1 = sd1 | inj1;

    uart_hex_reply_tx #(.DATA_W(32), .DBIT(8), .SEND_CRLF(1'b1), .UPPERCASE(1'b1)) dut0 (
        .clk(clk), .reset(reset), .result_valid(rv0), .result(res0), .result_ready(rdy0),
        .tx_done_tick(done0), .tx_start(ts0), .tx_din(din0), .busy(busy0), .drop_count(drop0));

    uart_hex_reply_tx #(.DATA_W(32), .DBIT(8), .SEND_CRLF(1'b0), .UPPERCASE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .result_valid(rv1), .result(res1), .result_ready(rdy1),
        .tx_done_tick(done1), .tx_start(ts1), .tx_din(din1), .busy(busy1), .drop_count(drop1));

    // Stub uart_tx: done pulse 5 cycles after the tx_start cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        sd0 <= 1'b0;
        sd1 <= 1'b0;
        if (reset) cd0 <= 0;
        else if (ts0) cd0 <= 4;
        else if (cd0 > 0) begin cd0 <= cd0 - 1; if (cd0 == 1) sd0 <= 1'b1; end
        if (reset) cd1 <= 0;
        else if (ts1) cd1 <= 4;
        else if (cd1 > 0) begin cd1 <= cd1 - 1; if (cd1 == 1) sd1 <= 1'b1; end
    end

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: instance 0 uppercase with CR LF (10 chars), instance 1 lowercase digits only (8 chars).
    function automatic logic [7:0] model_char(input int d, input logic [31:0] v, input int i);
        int n;
        if (i < 8) begin
            n = int'((v >> (28 - 4 * i)) & 32'hF);
            if (n < 10) return 8'(48 + n);
            return 8'(((d == 0) ? 65 : 97) + n - 10);
        end
        if (i == 8) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic int frame_len(input int d);
        return (d == 0) ? 10 : 8;
    endfunction

    bit          mon_en = 1'b0;
    bit          m_active[2], m_wait[2];
    int          m_idx[2], m_next[2], m_drops[2];
    logic [31:0] m_val[2];
    logic [7:0]  m_hold[2];
    int          log_n[2];
    int          log_cyc[2][16];
    logic [7:0]  log_din[2][16];

    task automatic mon_step(input int d, input logic ts, input logic [7:0] din, input logic bsy,
                            input logic rdy, input logic [7:0] drp, input logic dn,
                            input logic rv, input logic [31:0] res);
        bit act_now, was_wait, exp_ts;
        act_now  = m_active[d];
        was_wait = m_wait[d];
        chk($sformatf("busy%0d", d), {31'd0, bsy}, {31'd0, act_now});
        chk($sformatf("result_ready%0d", d), {31'd0, rdy}, {31'd0, !act_now});
        chk($sformatf("drop_count%0d", d), {24'd0, drp}, m_drops[d]);
        exp_ts = act_now && !was_wait && (cyc == m_next[d]);
        chk($sformatf("tx_start%0d", d), {31'd0, ts}, {31'd0, exp_ts});
        if (ts) begin
            chk($sformatf("tx_din%0d_char%0d", d, m_idx[d]), {24'd0, din}, {24'd0, model_char(d, m_val[d], m_idx[d])});
            if (log_n[d] < 16) begin
                log_cyc[d][log_n[d]] = cyc;
                log_din[d][log_n[d]] = din;
                log_n[d]++;
            end
            m_wait[d] = 1'b1;
            m_hold[d] = din;
        end else if (was_wait) begin
            chk($sformatf("tx_din%0d_stable", d), {24'd0, din}, {24'd0, m_hold[d]});
        end
        if (reset) begin
            m_active[d] = 1'b0;
            m_wait[d]   = 1'b0;
            m_drops[d]  = 0;
            m_idx[d]    = 0;
        end else begin
            if (dn && was_wait) begin
                m_wait[d] = 1'b0;
                if (m_idx[d] == frame_len(d) - 1) m_active[d] = 1'b0;
                else begin m_idx[d]++; m_next[d] = cyc + 1; end
            end
            if (rv) begin
                if (act_now) begin
                    if (m_drops[d] < 255) m_drops[d]++;
                end else begin
                    m_active[d] = 1'b1;
                    m_val[d]    = res;
                    m_idx[d]    = 0;
                    m_next[d]   = cyc + 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, ts0, din0, busy0, rdy0, drop0, done0, rv0, res0);
            mon_step(1, ts1, din1, busy1, rdy1, drop1, done1, rv1, res1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse0(input logic [31:0] v);
        rv0 = 1'b1; res0 = v; tick(); rv0 = 1'b0; res0 = 32'hDEADBEEF;
    endtask

    task automatic pulse1(input logic [31:0] v);
        rv1 = 1'b1; res1 = v; tick(); rv1 = 1'b0; res1 = 32'hCAFEF00D;
    endtask

    task automatic wait_idle(input int d, input string name);
        int n = 0;
        while (((d == 0) ? busy0 : busy1) || m_active[d]) begin
            if (n >= 300) begin chk({name, "_idle_timeout"}, 32'd0, 32'd1); return; end
            tick(); n++;
        end
    endtask

    task automatic wait_starts(input int d, input int k, input string name);
        int n = 0;
        while (log_n[d] < k) begin
            if (n >= 300) begin chk({name, "_start_timeout"}, log_n[d], k); return; end
            tick(); n++;
        end
    endtask

    logic [7:0] lit10 [10];
    logic [7:0] lit78 [10];
    int         lit_st [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, s, n;
        lit10  = '{8'h30, 8'h30, 8'h33, 8'h37, 8'h35, 8'h46, 8'h30, 8'h30, 8'h0D, 8'h0A};
        lit78  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h38, 8'h0D, 8'h0A};
        lit_st = '{1, 7, 13};
        reset = 1'b1; rv0 = 1'b0; rv1 = 1'b0; res0 = '0; res1 = '0; inj0 = 1'b0; inj1 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_tx_start0", {31'd0, ts0}, 32'd0);
        chk("rst_tx_din0", {24'd0, din0}, 32'd0);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_ready0", {31'd0, rdy0}, 32'd1);
        chk("rst_drop0", {24'd0, drop0}, 32'd0);
        chk("rst_tx_start1", {31'd0, ts1}, 32'd0);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_ready1", {31'd0, rdy1}, 32'd1);
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++)
            chk($sformatf("model_10fact_char%0d", i), {24'd0, model_char(0, 32'h00375F00, i)}, {24'd0, lit10[i]});
        for (int i = 0; i < 8; i++)
            chk($sformatf("model_ffff_char%0d", i), {24'd0, model_char(1, 32'hFFFFFFFF, i)}, 32'h66);

        // 10! frame with start-cycle timing
        log_n[0] = 0; c0 = cyc;
        pulse0(32'h00375F00);
        wait_idle(0, "t1");
        chk("t1_busy_low_after_last_done", cyc - log_cyc[0][9], 32'd6);
        chk("t1_starts", log_n[0], 32'd10);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t3_start%0d_offset", k), log_cyc[0][k] - c0, lit_st[k]);
        for (int k = 0; k < 10; k++)
            chk($sformatf("t1_din%0d", k), {24'd0, log_din[0][k]}, {24'd0, lit10[k]});

        // All-F, lowercase, no CR LF
        log_n[1] = 0;
        pulse1(32'hFFFFFFFF);
        wait_idle(1, "t2");
        chk("t2_starts", log_n[1], 32'd8);
        chk("t2_ready", {31'd0, rdy1}, 32'd1);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t2_din%0d", k), {24'd0, log_din[1][k]}, 32'h66);

        // Drop during byte 3
        log_n[0] = 0;
        pulse0(32'h00375F00);
        wait_starts(0, 3, "t4");
        tick(); tick();
        rv0 = 1'b1; res0 = 32'h1; tick(); rv0 = 1'b0;
        wait_idle(0, "t4");
        chk("t4_drop_count", {24'd0, drop0}, 32'd1);
        chk("t4_starts", log_n[0], 32'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("t4_din%0d", k), {24'd0, log_din[0][k]}, {24'd0, lit10[k]});

        // Pulse on the final done is dropped; the next cycle's pulse is accepted
        log_n[0] = 0;
        pulse0(32'h00375F00);
        wait_starts(0, 10, "t5");
        s = log_cyc[0][9];
        n = 0;
        while (cyc < s + 5 && n < 20) begin tick(); n++; end
        rv0 = 1'b1; res0 = 32'h1234; tick();
        res0 = 32'h00000078; tick();
        rv0 = 1'b0; res0 = 32'hDEADBEEF;
        log_n[0] = 0;
        chk("t5_drop_count", {24'd0, drop0}, 32'd2);
        chk("t5_accepted", {31'd0, busy0}, 32'd1);
        inj0 = 1'b1; tick(); inj0 = 1'b0;
        wait_idle(0, "t5");
        chk("t5_starts", log_n[0], 32'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("t5_din%0d", k), {24'd0, log_din[0][k]}, {24'd0, lit78[k]});
        inj0 = 1'b1; tick(); inj0 = 1'b0;
        repeat (3) tick();
        chk("t5_idle_done_ignored", {31'd0, busy0}, 32'd0);

        // Saturate drop_count
        for (int f = 0; f < 6; f++) begin
            pulse0(32'hA5A5A5A5);
            for (int j = 0; j < 200; j++) begin
                rv0 = busy0;
                if (!busy0) break;
                tick();
            end
            rv0 = 1'b0;
        end
        chk("t4_drop_saturated", {24'd0, drop0}, 32'd255);

        // Reset during WAIT of byte 4
        log_n[0] = 0;
        pulse0(32'h00375F00);
        wait_starts(0, 4, "t6");
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_busy", {31'd0, busy0}, 32'd0);
        chk("t6_tx_start", {31'd0, ts0}, 32'd0);
        chk("t6_drop_count", {24'd0, drop0}, 32'd0);
        chk("t6_ready", {31'd0, rdy0}, 32'd1);
        repeat (2) tick();
        log_n[0] = 0;
        pulse0(32'h00000078);
        wait_idle(0, "t6");
        chk("t6_starts", log_n[0], 32'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("t6_din%0d", k), {24'd0, log_din[0][k]}, {24'd0, lit78[k]});

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
